ripple_count_monitor: RTL

- Synchronous downstream consumer of the 4-bit JK ripple counter outputs (`qa` LSB … `qd` MSB).
- Resynchronises the asynchronous, glitch-prone ripple bits into the `clk` domain and filters ripple transients by requiring a stable value.
- Publishes the accepted count, a seven-segment pattern, a wrap event/counter and a sticky sequence-error flag.
- Sits between the ripple counter and the display/status logic.

---
 rtl/ripple_count_monitor.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: synchronises and de-glitches the 4-bit JK ripple counter
// outputs, then publishes the accepted count, its seven-segment pattern, wrap
// events and a sticky error for any non-sequential step.
//
// Ports:
//   clk, clr            - single clock, synchronous active-high clear
//   qa..qd              - raw ripple bits (qa = LSB), asynchronous to clk
//   count, valid        - last accepted value; valid once anything was accepted
//   seg                 - registered seven-segment pattern (seg[0]=a .. seg[6]=g)
//   wrap_pulse/wrap_cnt - one-cycle 15->0 pulse and modulo-2^WRAP_W wrap counter
//   err                 - sticky non-sequential-step flag
//
// Optional feature macro: RIPPLE_COUNT_MONITOR_SEG_EN (hex decoder on seg;
// when undefined seg is tied to all-zero).
module ripple_count_monitor #(
  parameter int STABLE_CYCLES = 2,  // 1..7
  parameter int WRAP_W        = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              qa,
  input  logic              qb,
  input  logic              qc,
  input  logic              qd,
  output logic [3:0]        count,
  output logic              valid,
  output logic [6:0]        seg,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err
);

  localparam logic [2:0] RUN_MAX = 3'(STABLE_CYCLES);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_n;

  logic [3:0]          s1;
  logic [3:0]          s2;
  // Track whether each synchroniser stage holds a real post-clear sample, so the
  // cleared value of s2 is never mistaken for a stable input.
  logic                s1_live;
  logic                s2_live;
  logic [2:0]          run;

  logic                accept;
  logic [3:0]          count_inc;
  logic [3:0]          count_n;
  logic                valid_n;
  logic                wrap_pulse_n;
  logic [WRAP_W-1:0]   wrap_cnt_n;
  logic                err_n;

  // Two-stage synchroniser plus the run-length (stability) counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      s1      <= 4'd0;
      s2      <= 4'd0;
      s1_live <= 1'b0;
      s2_live <= 1'b0;
      run     <= 3'd0;
    end else begin
      s1      <= {qd, qc, qb, qa};
      s1_live <= 1'b1;
      s2      <= s1;
      s2_live <= s1_live;
      if (!s1_live) begin
        run <= 3'd0;
      end else if (!s2_live || (s1 != s2)) begin
        // s2 is about to take a new value: its run starts at one cycle.
        run <= 3'd1;
      end else if (run < RUN_MAX) begin
        run <= run + 3'd1;
      end
    end
  end

  // A value is taken once it has been stable long enough and actually differs
  // from what is already published.
  assign accept    = (run == RUN_MAX) && ((state == ST_INIT) || (s2 != count));
  assign count_inc = count + 4'd1;

  // State and published-output registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_INIT;
      count      <= 4'd0;
      valid      <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      valid      <= valid_n;
      wrap_pulse <= wrap_pulse_n;
      wrap_cnt   <= wrap_cnt_n;
      err        <= err_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_INIT: if (accept) state_n = ST_RUN;
      ST_RUN:  state_n = ST_RUN;
      default: state_n = ST_INIT;
    endcase
  end

  // Output logic: next values of the published registers.
  always_comb begin
    count_n      = count;
    valid_n      = valid;
    wrap_pulse_n = 1'b0;
    wrap_cnt_n   = wrap_cnt;
    err_n        = err;
    if (accept) begin
      count_n = s2;
      valid_n = 1'b1;
      // The very first acceptance has no predecessor to check against.
      if (state == ST_RUN) begin
        if (s2 != count_inc) begin
          err_n = 1'b1;
        end
        if ((count == 4'hF) && (s2 == 4'h0)) begin
          wrap_pulse_n = 1'b1;
          wrap_cnt_n   = wrap_cnt + WRAP_W'(1);
        end
      end
    end
  end

`ifdef RIPPLE_COUNT_MONITOR_SEG_EN
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'b0111111;
      4'h1: p = 7'b0000110;
      4'h2: p = 7'b1011011;
      4'h3: p = 7'b1001111;
      4'h4: p = 7'b1100110;
      4'h5: p = 7'b1101101;
      4'h6: p = 7'b1111101;
      4'h7: p = 7'b0000111;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1101111;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b1111100;
      4'hC: p = 7'b0111001;
      4'hD: p = 7'b1011110;
      4'hE: p = 7'b1111001;
      default: p = 7'b1110001;
    endcase
    return p;
  endfunction

  // Loaded on the same edge as count so the display never lags the value.
  always_ff @(posedge clk) begin
    if (clr) begin
      seg <= 7'b0000000;
    end else if (accept) begin
      seg <= hex7(s2);
    end
  end
`else
  assign seg = 7'b0000000;
`endif

endmodule
